// File: rtl/key_sw_input_conditioner_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | input_cond_pkg                                                           |
// | Shared sizes and constants for the KEY/SW input conditioner.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package input_cond_pkg;
   localparam int N_KEY = 4;
   localparam int N_SW  = 10;
   localparam int N_IN  = N_KEY + N_SW;

   // KEYs occupy the low channels and are wired active low on the board
   localparam logic [N_IN-1:0] KEY_ACTIVE_LOW_MASK = {{N_SW{1'b0}}, {N_KEY{1'b1}}};

   localparam int DEBOUNCE_1MS_50MHZ = 50000;
endpackage
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | debounce_chan                                                            |
// | One channel: 2-flop sync, polarity fix, counter debounce, edge pulses.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module debounce_chan
   import input_cond_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = DEBOUNCE_1MS_50MHZ,
   parameter logic ACTIVE_LOW      = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int               c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

   logic               r_s1;
   logic               r_s2;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_level;
   logic               r_level_d;
   logic               r_rise;
   logic               r_fall;
   logic               w_norm;

   assign w_norm = r_s2 ^ ACTIVE_LOW;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // Sync flops start at the pin's idle level so no false edge follows reset
         r_s1      <= ACTIVE_LOW;
         r_s2      <= ACTIVE_LOW;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_rise    <= 1'b0;
         r_fall    <= 1'b0;
      end else begin
         r_s1      <= raw_i;
         r_s2      <= r_s1;
         r_level_d <= r_level;
         r_rise    <= r_level & ~r_level_d;
         r_fall    <= ~r_level & r_level_d;
         if (w_norm == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == c_cnt_last) begin
            r_level <= w_norm;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
         end
      end
   end

   assign level_o = r_level;
   assign rise_o  = r_rise;
   assign fall_o  = r_fall;

endmodule
`default_nettype wire

// File: rtl/key_sw_input_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_sw_input_conditioner                                                 |
// | Debounced KEY/SW levels, edge pulses and sticky maskable interrupts.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module key_sw_input_conditioner
   import input_cond_pkg::*;
#(
   parameter int              N_IN            = input_cond_pkg::N_IN,
   parameter int              DEBOUNCE_CYCLES = input_cond_pkg::DEBOUNCE_1MS_50MHZ,
   parameter logic [N_IN-1:0] ACTIVE_LOW_MASK = input_cond_pkg::KEY_ACTIVE_LOW_MASK
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_IN-1:0] raw_i,
   input  logic [N_IN-1:0] irq_en_i,
   input  logic [N_IN-1:0] irq_clr_i,
   output logic [N_IN-1:0] level_o,
   output logic [N_IN-1:0] rise_o,
   output logic [N_IN-1:0] fall_o,
   output logic [N_IN-1:0] pending_o,
   output logic            irq_o
);

   logic [N_IN-1:0] r_pending;

   for (genvar gi = 0; gi < N_IN; gi++) begin : g_chan
      debounce_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW_MASK[gi])
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .raw_i   (raw_i[gi]),
         .level_o (level_o[gi]),
         .rise_o  (rise_o[gi]),
         .fall_o  (fall_o[gi])
      );
   end

   // Set term is OR-ed after the clear so a rise coinciding with a clear is kept
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~irq_clr_i) | (rise_o & irq_en_i);
      end
   end

   assign pending_o = r_pending;
   assign irq_o     = |r_pending;

endmodule
`default_nettype wire

// File: tb/tb_key_sw_input_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_key_sw_input_conditioner                                              |
// | Directed bench with short debounce window (4 cycles).                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_key_sw_input_conditioner;

   localparam int N = 14;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] raw_i;
   logic [N-1:0] irq_en_i;
   logic [N-1:0] irq_clr_i;
   logic [N-1:0] level_o;
   logic [N-1:0] rise_o;
   logic [N-1:0] fall_o;
   logic [N-1:0] pending_o;
   logic         irq_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   key_sw_input_conditioner #(
      .N_IN            (N),
      .DEBOUNCE_CYCLES (4),
      .ACTIVE_LOW_MASK (14'h000F)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_i     (raw_i),
      .irq_en_i  (irq_en_i),
      .irq_clr_i (irq_clr_i),
      .level_o   (level_o),
      .rise_o    (rise_o),
      .fall_o    (fall_o),
      .pending_o (pending_o),
      .irq_o     (irq_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      raw_i     = 14'h000F;
      irq_en_i  = '0;
      irq_clr_i = '0;

      // 1: reset, then idle
      for (int i = 0; i < 5; i++) tick();
      chk("reset_state", {level_o, rise_o, fall_o, pending_o, 7'b0, irq_o}, 64'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle", {level_o, rise_o, fall_o, pending_o, 7'b0, irq_o}, 64'd0);
      end

      // 2: press KEY0 with interrupt enabled
      irq_en_i[0] = 1'b1;
      raw_i[0]    = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (i == 5) chk("t2_level_pre", 64'(level_o[0]), 64'd0);
         if (i == 6) begin
            chk("t2_level", 64'(level_o[0]), 64'd1);
            chk("t2_rise_early", 64'(rise_o[0]), 64'd0);
         end
         if (i == 7) begin
            chk("t2_rise", 64'(rise_o[0]), 64'd1);
            chk("t2_pend_early", 64'(pending_o[0]), 64'd0);
         end
         if (i == 8) begin
            chk("t2_rise_end", 64'(rise_o[0]), 64'd0);
            chk("t2_pend", 64'(pending_o), 64'h0001);
            chk("t2_irq", 64'(irq_o), 64'd1);
         end
      end
      raw_i[0] = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 5) chk("t2_rel_level_pre", 64'(level_o[0]), 64'd1);
         if (i == 6) chk("t2_rel_level", 64'(level_o[0]), 64'd0);
         if (i == 7) chk("t2_fall", {32'(fall_o[0]), 32'(rise_o[0])}, {32'd1, 32'd0});
         if (i == 8) chk("t2_fall_end_pend", {32'(fall_o[0]), 32'(pending_o[0])}, {32'd0, 32'd1});
      end

      // 3: 3-cycle glitch on KEY1 is rejected
      irq_en_i[1] = 1'b1;
      raw_i[1]    = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      raw_i[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t3_glitch", {32'(level_o[1]), 16'(rise_o[1]), 16'(pending_o[1])}, 64'd0);
      end

      // 4: clear coinciding with a new rise keeps the pending bit
      raw_i[0] = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("t4_level", 64'(level_o[0]), 64'd1);
      tick();
      chk("t4_rise", 64'(rise_o[0]), 64'd1);
      irq_clr_i[0] = 1'b1;
      tick();
      chk("t4_set_wins", 64'(pending_o[0]), 64'd1);
      tick();
      chk("t4_cleared", 64'(pending_o), 64'd0);
      chk("t4_irq_low", 64'(irq_o), 64'd0);
      irq_clr_i = '0;
      raw_i[0]  = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk("t4_settled", {32'(level_o), 32'(pending_o)}, 64'd0);

      // 5: SW9 without interrupt enable
      irq_en_i  = '0;
      raw_i[13] = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 5) chk("t5_level_pre", 64'(level_o[13]), 64'd0);
         if (i == 6) chk("t5_level", 64'(level_o), 64'h2000);
         if (i == 7) chk("t5_rise", 64'(rise_o), 64'h2000);
         if (i == 8) chk("t5_no_pend", {32'(pending_o), 32'(irq_o)}, 64'd0);
      end

      // 6: reset mid-count, then full re-debounce on two channels
      raw_i[2] = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("t6_level_pre_rst", 64'(level_o), 64'h2000);
      rst_n = 1'b0;
      tick();
      chk("t6_rst", {level_o, rise_o, fall_o, pending_o, 7'b0, irq_o}, 64'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         if (i == 5) chk("t6_level_pre", 64'(level_o), 64'd0);
         if (i == 6) chk("t6_level", 64'(level_o), 64'h2004);
         if (i == 7) chk("t6_rise", {32'(rise_o), 32'(fall_o)}, {32'h2004, 32'd0});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
